icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised N-way set-associative instruction cache; successor to the fixed direct-mapped icache inside the caches wrapper.
- Sits between datapath fetch (imemREN/imemaddr/ihit/imemload) and the memory controller instruction channel (iREN/iaddr/iwait/iload).
- Adds:
  - configurable sets/ways/block size;
  - true-LRU replacement;
  - multi-word block fill FSM;
  - global invalidate;
  - hit/miss performance counters.

Parameters:
SETS, 8, number of sets; power of 2, >=2
WAYS, 2, associativity; power of 2, 1..8
WORDS, 2, 32-bit words per block; power of 2, 1..8

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
imemREN  in  1  datapath fetch request
imemaddr  in  32  fetch byte address; bits [1:0] ignored
ihit  out  1  fetch data valid this cycle
imemload  out  32  fetched instruction
icache_inv  in  1  invalidate all lines
iREN  out  1  memory read request
iaddr  out  32  memory word address, bits [1:0]=0
iwait  in  1  memory busy; iload valid the cycle iwait=0 while iREN=1
iload  in  32  memory read data
hit_cnt  out  32  count of ihit cycles
miss_cnt  out  32  count of fills started

Behaviour:
- Address split:
  - [1:0] byte offset;
  - next log2(WORDS) bits = word offset;
  - next log2(SETS) bits = index;
  - remaining bits = tag.
  - Widths derive from parameters; a field may be 0 bits wide.
- Storage per set/way: valid, tag, WORDS data words. Per set: WAYS ages, each log2(WAYS) bits.
- Reset (async, RST=1):
  - all valid bits 0; ages of way w = w; state IDLE; word counter 0;
  - ihit=0, iREN=0, iaddr=0, imemload=0, hit_cnt=0, miss_cnt=0.
- Hit (IDLE only):
  - imemREN=1 with a valid way whose tag matches → ihit=1 combinationally in the same cycle.
  - imemload = data[word offset] of that way.
  - LRU updated at the clock edge.
  - Zero-cycle latency.
- imemload is 0 whenever ihit=0.
- LRU update on access to way w with age a:
  - ways with age < a increment;
  - w age becomes 0;
  - ages stay a permutation of 0..WAYS-1.
- Victim selection:
  - the lowest-index invalid way;
  - otherwise the way with age WAYS-1.
- Victim is latched on entering FILL.
- Miss (IDLE, imemREN=1, no match, icache_inv=0):
  - ihit=0;
  - next state FILL;
  - latch tag/index;
  - counter=0;
  - miss_cnt++.
- FILL:
  - iREN=1; iaddr={tag,index,counter,2'b00}.
  - When iwait=0: write iload into victim data[counter].
    - If counter==WORDS-1: set victim valid and tag, apply LRU access to the victim, go IDLE.
    - Otherwise counter++.
  - ihit=0 throughout FILL.
- After a fill the FSM returns to IDLE, which re-evaluates the current request; it hits the next cycle (miss penalty WORDS memory transfers + 1 cycle).
- imemaddr changing during FILL: the fill completes for the latched block, then the new address is evaluated in IDLE.
- iwait held high indefinitely: iaddr and iREN held stable, no state change.
- icache_inv=1 (any state, highest priority after reset):
  - clears all valid bits at the edge;
  - FSM to IDLE; counter=0; ihit forced 0 that cycle;
  - a partial fill is discarded and never marked valid;
  - iREN drops the next cycle (the memory channel tolerates a dropped level request);
  - ages are untouched.
- Counters wrap modulo 2^32.
  - hit_cnt increments on each cycle ihit=1.
  - miss_cnt increments on each FILL entry.
- WAYS=1: the age logic degenerates; the victim is always way 0.

Decomposition:
- Shared package icache_pkg:
  - icache_state_t enum {IDLE, FILL};
  - functions computing offset/index/tag widths from SETS/WAYS/WORDS;
  - word_t reused from cpu_types_pkg.
- One sub-module: icache_lru.
  - Holds per-set age arrays.
  - Inputs: index, access valid, accessed way, valid-bit vector.
  - Output: victim way.
  - Async active-high reset to age=way index.

Test Plan:
- Reset: assert RST mid-FILL with iREN=1 → iREN=0, ihit=0, hit_cnt=miss_cnt=0 immediately; a following read of 0x100 misses.
- Cold miss (SETS=8, WAYS=2, WORDS=2): read 0x100; memory returns 0xAAAA0001 (iaddr 0x100) then 0xAAAA0002 (iaddr 0x104), each after 2 iwait cycles → next cycle ihit=1, imemload=0xAAAA0001. Read 0x104 → ihit same cycle, 0xAAAA0002, iREN stays 0.
- LRU eviction (same set 0):
  - fill 0x100 and 0x200; hit 0x100; read 0x300 → miss, replaces the 0x200 way;
  - then 0x100 hits; 0x200 misses.
  - miss_cnt=4 at end, hit_cnt counts each ihit cycle.
- Invalidate mid-fill: pulse icache_inv after the first word of the 0x100 fill → iREN=0 next cycle, state IDLE; re-read 0x100 → full 2-word fill again, miss_cnt+1.
- Stall: hold iwait=1 for 10 cycles during FILL, changing imemaddr to 0x400 → iaddr stays 0x100, ihit=0; fill completes, then 0x400 misses.
- WAYS=1, WORDS=1 build: alternating 0x100/0x120 (same index) → every access misses, single-word fills, iaddr equals the request address.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the N-way instruction cache.
package icache_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Bits selecting a word inside a block (may be 0).
  function automatic int woff_width(input int words);
    return $clog2(words);
  endfunction

  // Bits selecting a set.
  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  // Bits needed to name a way / hold an age (may be 0).
  function automatic int way_width(input int ways);
    return $clog2(ways);
  endfunction

  // Whatever is left of the 30-bit word address after offset and index.
  function automatic int tag_width(input int sets, input int words);
    return 30 - $clog2(words) - $clog2(sets);
  endfunction

  // Storage width for a field that may legitimately be 0 bits wide.
  function automatic int field_width(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU age tracking per set plus victim choice for the N-way icache.
module icache_lru
  import icache_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [index_width(SETS)-1:0]          idx_i,
  input  logic                                  acc_valid_i,
  input  logic [field_width(way_width(WAYS))-1:0] acc_way_i,
  input  logic [WAYS-1:0]                       valid_i,
  output logic [field_width(way_width(WAYS))-1:0] victim_o
);

  localparam int IDX_W  = index_width(SETS);
  localparam int WAY_SW = field_width(way_width(WAYS));
  localparam int NWP    = 1 << WAY_SW;  // way slots padded so the way index is fully decoded

  logic [WAY_SW-1:0] ages_q [SETS][NWP];
  logic [WAY_SW-1:0] row_q  [NWP];
  logic [WAY_SW-1:0] row_d  [NWP];
  logic [WAY_SW-1:0] acc_age;
  logic              found_inv;

  assign acc_age = row_q[acc_way_i];

  // Accessed way becomes youngest; every way younger than it ages by one.
  genvar gi;
  generate
    for (gi = 0; gi < NWP; gi++) begin : g_age
      assign row_q[gi] = ages_q[idx_i][gi];
      if (gi < WAYS) begin : g_live
        assign row_d[gi] = (acc_way_i == WAY_SW'(gi)) ? '0 :
                           (row_q[gi] < acc_age)      ? row_q[gi] + 1'b1 :
                                                        row_q[gi];
      end else begin : g_pad
        assign row_d[gi] = row_q[gi];
      end
    end
  endgenerate

  // Victim: lowest-index invalid way, else the oldest way.
  always_comb begin
    victim_o  = '0;
    found_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o  = WAY_SW'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (row_q[w] == WAY_SW'(WAYS - 1)) victim_o = WAY_SW'(w);
      end
    end
  end

  // Age storage; reset gives way w age w so ages start as a permutation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < NWP; w++) begin
          ages_q[s][w] <= WAY_SW'(w);
        end
      end
    end else if (acc_valid_i) begin
      ages_q[idx_i] <= row_d;
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with true-LRU replacement,
// multi-word block fill, global invalidate and hit/miss counters.
module icache_nway
  import icache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        icache_inv,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WOFF_W = woff_width(WORDS);
  localparam int IDX_W  = index_width(SETS);
  localparam int TAG_W  = tag_width(SETS, WORDS);
  localparam int OFF_SW = field_width(WOFF_W);
  localparam int WAY_SW = field_width(way_width(WAYS));
  localparam int NWP    = 1 << WAY_SW;   // padded way slots
  localparam int NWD    = 1 << OFF_SW;   // padded word slots
  localparam int IDX_SH = 2 + WOFF_W;
  localparam int TAG_SH = 2 + WOFF_W + IDX_W;

  // Cache storage
  logic [NWP-1:0]   valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][NWP];
  word_t            data_q  [SETS][NWP][NWD];

  // FSM and fill bookkeeping
  icache_state_t     state_q,    state_d;
  logic [OFF_SW-1:0] cnt_q,      cnt_d;
  logic [TAG_W-1:0]  tag_lat_q,  tag_lat_d;
  logic [IDX_W-1:0]  idx_lat_q,  idx_lat_d;
  logic [WAY_SW-1:0] victim_q,   victim_d;
  logic [31:0]       hit_cnt_q,  hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  // Request decode
  logic [OFF_SW-1:0] req_woff;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WAYS-1:0]   match;
  logic              hit_any;
  logic [WAY_SW-1:0] hit_way;
  logic              miss;
  logic              wr_word;
  logic              fill_last;

  // LRU interface
  logic [IDX_W-1:0]  lru_idx;
  logic              lru_acc;
  logic [WAY_SW-1:0] lru_way;
  logic [WAY_SW-1:0] lru_victim;
  logic [31:0]       fill_addr;

  assign req_woff = OFF_SW'((imemaddr >> 2) & 32'(WORDS - 1));
  assign req_idx  = IDX_W'(imemaddr >> IDX_SH);
  assign req_tag  = TAG_W'(imemaddr >> TAG_SH);

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign match[gi] = valid_q[req_idx][gi] && (tag_q[req_idx][gi] == req_tag);
    end
  endgenerate

  assign hit_any = |match;

  // Encode the matching way (tags are unique within a set, so at most one).
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) hit_way = WAY_SW'(w);
    end
  end

  assign ihit      = (state_q == IDLE) && imemREN && hit_any && !icache_inv;
  assign miss      = (state_q == IDLE) && imemREN && !hit_any && !icache_inv;
  assign wr_word   = (state_q == FILL) && !iwait && !icache_inv;
  assign fill_last = wr_word && (cnt_q == OFF_SW'(WORDS - 1));
  assign imemload  = ihit ? data_q[req_idx][hit_way][req_woff] : '0;

  assign fill_addr = (32'(tag_lat_q) << TAG_SH) | (32'(idx_lat_q) << IDX_SH) | (32'(cnt_q) << 2);
  assign iREN      = (state_q == FILL);
  assign iaddr     = (state_q == FILL) ? fill_addr : '0;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // During a fill the LRU looks at the latched set; otherwise at the request.
  assign lru_idx = (state_q == FILL) ? idx_lat_q : req_idx;
  assign lru_acc = ihit || fill_last;
  assign lru_way = (state_q == FILL) ? victim_q : hit_way;

  icache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk_i       (CLK),
    .rst_i       (RST),
    .idx_i       (lru_idx),
    .acc_valid_i (lru_acc),
    .acc_way_i   (lru_way),
    .valid_i     (valid_q[lru_idx][WAYS-1:0]),
    .victim_o    (lru_victim)
  );

  // Next-state logic: invalidate overrides everything, then IDLE/FILL handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_lat_d  = tag_lat_q;
    idx_lat_d  = idx_lat_q;
    victim_d   = victim_q;
    hit_cnt_d  = ihit ? hit_cnt_q + 32'd1 : hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (icache_inv) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            state_d    = FILL;
            cnt_d      = '0;
            tag_lat_d  = req_tag;
            idx_lat_d  = req_idx;
            victim_d   = lru_victim;
            miss_cnt_d = miss_cnt_q + 32'd1;
          end
        end
        FILL: begin
          if (!iwait) begin
            if (fill_last) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, fill latches and performance counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tag_lat_q  <= '0;
      idx_lat_q  <= '0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_lat_q  <= tag_lat_d;
      idx_lat_q  <= idx_lat_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Valid bits: cleared by reset or invalidate, set only when the last word lands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (icache_inv) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill_last) begin
      valid_q[idx_lat_q][victim_q] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (wr_word) data_q[idx_lat_q][victim_q][cnt_q] <= iload;
    if (fill_last) tag_q[idx_lat_q][victim_q] <= tag_lat_q;
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: default 8x2x2 build plus a 1-way, 1-word build.
module tb_icache_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemREN, icache_inv, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr, hit_cnt, miss_cnt;

  logic        imemREN1, icache_inv1, iwait1;
  logic [31:0] imemaddr1, iload1;
  logic        ihit1, iREN1;
  logic [31:0] imemload1, iaddr1, hit_cnt1, miss_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r_addr0, r_addr1;
  logic        r_ren_ok, r_nohit, r_req_hit;

  always #5 clk = ~clk;

  icache_nway #(.SETS(8), .WAYS(2), .WORDS(2)) u_dut (
    .CLK(clk), .RST(rst), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .icache_inv(icache_inv), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  icache_nway #(.SETS(8), .WAYS(1), .WORDS(1)) u_dut1 (
    .CLK(clk), .RST(rst), .imemREN(imemREN1), .imemaddr(imemaddr1), .ihit(ihit1),
    .imemload(imemload1), .icache_inv(icache_inv1), .iREN(iREN1), .iaddr(iaddr1),
    .iwait(iwait1), .iload(iload1), .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imemREN = 0; icache_inv = 0; iwait = 1; iload = 0; imemaddr = 0;
    imemREN1 = 0; icache_inv1 = 0; iwait1 = 1; iload1 = 0; imemaddr1 = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Drives the memory side of a 2-word fill; the DUT must already be in FILL.
  task automatic run_fill(input int waits, input logic [31:0] d0, input logic [31:0] d1);
    r_ren_ok = 1'b1;
    r_nohit  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iwait = 1;
      for (int j = 0; j < waits; j++) begin
        #1;
        r_ren_ok &= iREN;
        r_nohit  &= ~ihit;
        tick();
      end
      iwait = 0;
      iload = (k == 0) ? d0 : d1;
      #1;
      if (k == 0) r_addr0 = iaddr; else r_addr1 = iaddr;
      r_ren_ok &= iREN;
      r_nohit  &= ~ihit;
      tick();
    end
    iwait = 1;
    iload = 0;
  endtask

  // Presents a missing address, lets the FSM enter FILL, then completes the fill.
  task automatic req_fill(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                          input int waits);
    imemaddr = addr;
    imemREN  = 1;
    #1;
    r_req_hit = ihit;
    tick();
    run_fill(waits, d0, d1);
  endtask

  task automatic test_reset();
    rst = 1;
    imemREN = 0; icache_inv = 0; iwait = 1; iload = 0; imemaddr = 0;
    imemREN1 = 0; icache_inv1 = 0; iwait1 = 1; iload1 = 0; imemaddr1 = 0;
    tick(); tick();
    n_cmp++; if ({ihit, iREN} !== 2'b00) begin n_bad++; $display("FAIL rst_ihit_iren: got %b want 00", {ihit, iREN}); end
    n_cmp++; if (iaddr !== 32'h0) begin n_bad++; $display("FAIL rst_iaddr: got %h want 0", iaddr); end
    n_cmp++; if (imemload !== 32'h0) begin n_bad++; $display("FAIL rst_imemload: got %h want 0", imemload); end
    n_cmp++; if ({hit_cnt, miss_cnt} !== 64'h0) begin n_bad++; $display("FAIL rst_counters: got %h/%h want 0/0", hit_cnt, miss_cnt); end
    n_cmp++; if ({ihit1, iREN1, iaddr1, hit_cnt1, miss_cnt1} !== 98'h0) begin n_bad++; $display("FAIL rst_w1_outputs: got %b %b %h %h %h want all 0", ihit1, iREN1, iaddr1, hit_cnt1, miss_cnt1); end
    rst = 0;
    imemaddr = 32'h100;
    imemREN  = 1;
    tick();
    n_cmp++; if (iREN !== 1'b1) begin n_bad++; $display("FAIL rst_pre_fill_iren: got %b want 1", iREN); end
    n_cmp++; if (miss_cnt !== 32'd1) begin n_bad++; $display("FAIL rst_pre_miss_cnt: got %0d want 1", miss_cnt); end
    #2;
    rst = 1;
    #1;
    n_cmp++; if ({ihit, iREN} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_fill_iren: got %b want 00", {ihit, iREN}); end
    n_cmp++; if ({hit_cnt, miss_cnt} !== 64'h0) begin n_bad++; $display("FAIL rst_mid_fill_counters: got %h/%h want 0/0", hit_cnt, miss_cnt); end
    tick();
    rst = 0;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL rst_reread_ihit: got %b want 0", ihit); end
    tick();
    n_cmp++; if ({iREN, iaddr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL rst_reread_fill: got %b %h want 1 00000100", iREN, iaddr); end
    do_reset();
  endtask

  task automatic test_cold_miss();
    imemaddr = 32'h100;
    imemREN  = 1;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL cold_req_ihit: got %b want 0", ihit); end
    tick();
    n_cmp++; if ({iREN, iaddr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL cold_fill_start: got %b %h want 1 00000100", iREN, iaddr); end
    n_cmp++; if (miss_cnt !== 32'd1) begin n_bad++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    run_fill(2, 32'hAAAA0001, 32'hAAAA0002);
    n_cmp++; if (r_addr0 !== 32'h100) begin n_bad++; $display("FAIL cold_iaddr0: got %h want 00000100", r_addr0); end
    n_cmp++; if (r_addr1 !== 32'h104) begin n_bad++; $display("FAIL cold_iaddr1: got %h want 00000104", r_addr1); end
    n_cmp++; if ({r_ren_ok, r_nohit} !== 2'b11) begin n_bad++; $display("FAIL cold_fill_levels: got ren_ok=%b nohit=%b want 1 1", r_ren_ok, r_nohit); end
    #1;
    n_cmp++; if ({ihit, iREN} !== 2'b10) begin n_bad++; $display("FAIL cold_after_fill_hit: got ihit=%b iREN=%b want 1 0", ihit, iREN); end
    n_cmp++; if (imemload !== 32'hAAAA0001) begin n_bad++; $display("FAIL cold_load_w0: got %h want aaaa0001", imemload); end
    tick();
    imemaddr = 32'h104;
    #1;
    n_cmp++; if ({ihit, iREN} !== 2'b10) begin n_bad++; $display("FAIL cold_w1_hit: got ihit=%b iREN=%b want 1 0", ihit, iREN); end
    n_cmp++; if (imemload !== 32'hAAAA0002) begin n_bad++; $display("FAIL cold_load_w1: got %h want aaaa0002", imemload); end
    tick();
    imemREN = 0;
    #1;
    n_cmp++; if ({ihit, imemload} !== 33'h0) begin n_bad++; $display("FAIL cold_idle_out: got %b %h want 0 0", ihit, imemload); end
    n_cmp++; if ({hit_cnt, miss_cnt} !== {32'd2, 32'd1}) begin n_bad++; $display("FAIL cold_counters: got %0d/%0d want 2/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_lru_evict();
    do_reset();
    req_fill(32'h100, 32'hA1, 32'hA2, 0);
    n_cmp++; if (r_req_hit !== 1'b0) begin n_bad++; $display("FAIL lru_100_req: got %b want 0", r_req_hit); end
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hA1}) begin n_bad++; $display("FAIL lru_100_hit: got %b %h want 1 000000a1", ihit, imemload); end
    tick();
    req_fill(32'h200, 32'hB1, 32'hB2, 1);
    n_cmp++; if ({r_req_hit, r_addr0} !== {1'b0, 32'h200}) begin n_bad++; $display("FAIL lru_200_fill: got %b %h want 0 00000200", r_req_hit, r_addr0); end
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hB1}) begin n_bad++; $display("FAIL lru_200_hit: got %b %h want 1 000000b1", ihit, imemload); end
    tick();
    imemaddr = 32'h104;
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hA2}) begin n_bad++; $display("FAIL lru_rehit_100: got %b %h want 1 000000a2", ihit, imemload); end
    tick();
    req_fill(32'h300, 32'hC1, 32'hC2, 0);
    n_cmp++; if ({r_req_hit, r_addr1} !== {1'b0, 32'h304}) begin n_bad++; $display("FAIL lru_300_fill: got %b %h want 0 00000304", r_req_hit, r_addr1); end
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hC1}) begin n_bad++; $display("FAIL lru_300_hit: got %b %h want 1 000000c1", ihit, imemload); end
    tick();
    imemaddr = 32'h100;
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hA1}) begin n_bad++; $display("FAIL lru_100_kept: got %b %h want 1 000000a1", ihit, imemload); end
    tick();
    imemaddr = 32'h204;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL lru_200_evicted: got %b want 0", ihit); end
    tick();
    n_cmp++; if ({iREN, iaddr} !== {1'b1, 32'h200}) begin n_bad++; $display("FAIL lru_200_refill: got %b %h want 1 00000200", iREN, iaddr); end
    run_fill(0, 32'hD1, 32'hD2);
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hD2}) begin n_bad++; $display("FAIL lru_200_refill_hit: got %b %h want 1 000000d2", ihit, imemload); end
    tick();
    imemREN = 0;
    #1;
    n_cmp++; if ({hit_cnt, miss_cnt} !== {32'd6, 32'd4}) begin n_bad++; $display("FAIL lru_counters: got %0d/%0d want 6/4", hit_cnt, miss_cnt); end
  endtask

  task automatic test_invalidate();
    do_reset();
    req_fill(32'h100, 32'hE1, 32'hE2, 0);
    #1;
    n_cmp++; if (ihit !== 1'b1) begin n_bad++; $display("FAIL inv_pre_hit: got %b want 1", ihit); end
    tick();
    icache_inv = 1;
    #1;
    n_cmp++; if ({ihit, imemload} !== 33'h0) begin n_bad++; $display("FAIL inv_forces_miss: got %b %h want 0 0", ihit, imemload); end
    tick();
    icache_inv = 0;
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL inv_cleared_valid: got %b want 0", ihit); end
    tick();
    n_cmp++; if ({iREN, miss_cnt} !== {1'b1, 32'd2}) begin n_bad++; $display("FAIL inv_refill_start: got %b %0d want 1 2", iREN, miss_cnt); end
    iwait = 0;
    iload = 32'hBAD0;
    tick();
    iwait = 1;
    icache_inv = 1;
    #1;
    n_cmp++; if ({iREN, iaddr} !== {1'b1, 32'h104}) begin n_bad++; $display("FAIL inv_mid_fill_word1: got %b %h want 1 00000104", iREN, iaddr); end
    tick();
    icache_inv = 0;
    #1;
    n_cmp++; if ({iREN, iaddr, ihit} !== {1'b0, 32'h0, 1'b0}) begin n_bad++; $display("FAIL inv_fill_dropped: got %b %h %b want 0 0 0", iREN, iaddr, ihit); end
    tick();
    n_cmp++; if ({iREN, iaddr, miss_cnt} !== {1'b1, 32'h100, 32'd3}) begin n_bad++; $display("FAIL inv_full_refill: got %b %h %0d want 1 00000100 3", iREN, iaddr, miss_cnt); end
    run_fill(0, 32'hF1, 32'hF2);
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hF1}) begin n_bad++; $display("FAIL inv_refill_hit: got %b %h want 1 000000f1", ihit, imemload); end
    imemaddr = 32'h104;
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'hF2}) begin n_bad++; $display("FAIL inv_refill_w1: got %b %h want 1 000000f2", ihit, imemload); end
    imemREN = 0;
  endtask

  task automatic test_stall();
    do_reset();
    imemaddr = 32'h100;
    imemREN  = 1;
    tick();
    iwait    = 1;
    imemaddr = 32'h400;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++; if ({iREN, ihit, iaddr} !== {1'b1, 1'b0, 32'h100}) begin n_bad++; $display("FAIL stall_hold_c%0d: got %b %b %h want 1 0 00000100", c, iREN, ihit, iaddr); end
      tick();
    end
    run_fill(0, 32'h51, 32'h52);
    n_cmp++; if ({r_addr0, r_addr1} !== {32'h100, 32'h104}) begin n_bad++; $display("FAIL stall_fill_addrs: got %h %h want 00000100 00000104", r_addr0, r_addr1); end
    #1;
    n_cmp++; if ({ihit, iREN} !== 2'b00) begin n_bad++; $display("FAIL stall_new_addr_miss: got %b %b want 0 0", ihit, iREN); end
    tick();
    n_cmp++; if ({iREN, iaddr, miss_cnt} !== {1'b1, 32'h400, 32'd2}) begin n_bad++; $display("FAIL stall_400_fill: got %b %h %0d want 1 00000400 2", iREN, iaddr, miss_cnt); end
    run_fill(0, 32'h61, 32'h62);
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'h61}) begin n_bad++; $display("FAIL stall_400_hit: got %b %h want 1 00000061", ihit, imemload); end
    tick();
    imemaddr = 32'h104;
    #1;
    n_cmp++; if ({ihit, imemload} !== {1'b1, 32'h52}) begin n_bad++; $display("FAIL stall_100_kept: got %b %h want 1 00000052", ihit, imemload); end
    imemREN = 0;
  endtask

  task automatic test_ways1();
    logic [31:0] a, d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'h100 : 32'h120;
      d = 32'h1111_0000 + 32'(i);
      imemaddr1 = a;
      imemREN1  = 1;
      #1;
      n_cmp++; if (ihit1 !== 1'b0) begin n_bad++; $display("FAIL w1_miss_%0d: got %b want 0", i, ihit1); end
      tick();
      n_cmp++; if ({iREN1, iaddr1} !== {1'b1, a}) begin n_bad++; $display("FAIL w1_iaddr_%0d: got %b %h want 1 %h", i, iREN1, iaddr1, a); end
      iwait1 = 0;
      iload1 = d;
      tick();
      iwait1 = 1;
      #1;
      n_cmp++; if ({ihit1, imemload1} !== {1'b1, d}) begin n_bad++; $display("FAIL w1_hit_%0d: got %b %h want 1 %h", i, ihit1, imemload1, d); end
      tick();
    end
    imemREN1 = 0;
    #1;
    n_cmp++; if ({hit_cnt1, miss_cnt1} !== {32'd4, 32'd4}) begin n_bad++; $display("FAIL w1_counters: got %0d/%0d want 4/4", hit_cnt1, miss_cnt1); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_lru_evict();
    test_invalidate();
    test_stall();
    test_ways1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
